// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the fetch stage: data width, canonical NOP
// and the fetch control states.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FAULT = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // JALR targets have bit 0 forced to zero before use.
    function automatic logic [XLEN-1:0] clearBit0(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with push, pop, flush and an occupancy count.
// The head entry is presented combinationally on head_o.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rdPtr_q;
    logic [PW-1:0]    wrPtr_q;
    logic [CW-1:0]    count_q;
    logic             doPush;
    logic             doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign doPop   = pop_i & (count_q != '0);
    assign doPush  = push_i & ((count_q != CW'(DEPTH)) | doPop);
    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    // Storage, pointers and count; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= push_data_i;
                wrPtr_q        <= nextPtr(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            if (doPush && !doPop) begin
                count_q <= count_q + CW'(1);
            end else if (doPop && !doPush) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, issues in-order imem requests under a
// credit limit, buffers returned words for decode and restarts fetch on
// execute redirects, discarding wrong-path responses still in flight.
module instr_fetch
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_misaligned
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DepthL = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   faultPc_q, faultPc_d;
    logic [CW-1:0]     dropCnt_q, dropCnt_d;

    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     bufCount;
    logic [XLEN-1:0]   rspPc;
    logic [2*XLEN-1:0] bufHead;
    logic [XLEN-1:0]   target;
    logic              creditOk;
    logic              reqFire;
    logic              dropRsp;
    logic              bufPush;
    logic              bufPop;

    assign target   = clearBit0(redirect_pc);
    assign creditOk = ({1'b0, outstanding} + {1'b0, bufCount}) < DepthL;
    assign reqFire  = imem_req_valid & imem_req_ready;
    assign dropRsp  = imem_rsp_valid & (redirect_valid | (dropCnt_q != '0));
    assign bufPush  = imem_rsp_valid & ~dropRsp;
    assign bufPop   = if_valid & if_ready & (state_q == RUN);
    assign imem_req_addr = pc_q;

    // PCs of requests in flight, popped as responses return in order.
    sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pcQueue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (reqFire),
        .push_data_i (pc_q),
        .pop_i       (imem_rsp_valid),
        .flush_i     (1'b0),
        .head_o      (rspPc),
        .count_o     (outstanding)
    );

    // {pc, instr} pairs waiting for decode; wiped on every redirect.
    sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(FIFO_DEPTH)) u_instrBuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (bufPush),
        .push_data_i ({rspPc, imem_rsp_data}),
        .pop_i       (bufPop),
        .flush_i     (redirect_valid),
        .head_o      (bufHead),
        .count_o     (bufCount)
    );

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            faultPc_q <= '0;
            dropCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            faultPc_q <= faultPc_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    // Next-state and decode-side outputs; requests are held low while in
    // reset so every output reads zero until rst_n is released.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        faultPc_d      = faultPc_q;
        dropCnt_d      = dropCnt_q;
        imem_req_valid = rst_n & (state_q == RUN) & ~redirect_valid & creditOk;
        if_valid       = 1'b0;
        if_pc          = '0;
        if_instr       = '0;
        if_misaligned  = 1'b0;

        case (state_q)
            RUN: begin
                if_valid = (bufCount != '0) & ~redirect_valid;
                if (if_valid) begin
                    if_pc    = bufHead[2*XLEN-1:XLEN];
                    if_instr = bufHead[XLEN-1:0];
                end
            end
            FAULT: begin
                if_valid = ~redirect_valid;
                if (if_valid) begin
                    if_pc         = faultPc_q;
                    if_instr      = NOP_INSTR;
                    if_misaligned = 1'b1;
                end
                if (if_ready && !redirect_valid) begin
                    state_d = HALT;
                end
            end
            default: begin
                if_valid = 1'b0;
            end
        endcase

        if (reqFire) begin
            pc_d = pc_q + 32'd4;
        end
        if (imem_rsp_valid && dropCnt_q != '0) begin
            dropCnt_d = dropCnt_q - CW'(1);
        end

        if (redirect_valid) begin
            dropCnt_d = outstanding - CW'(imem_rsp_valid);
            if (target[1]) begin
                state_d   = FAULT;
                faultPc_d = target;
            end else begin
                state_d = RUN;
                pc_d    = target;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch: an imem model with random
// latency, a program-order reference of what decode must see, and directed
// phases for reset, back-pressure, redirects and misaligned targets.
module tb_instr_fetch;
    import rv32_pkg::*;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } expEntry_t;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_misaligned;

    expEntry_t   expQ[$];
    logic [31:0] pendAddr[$];
    int          pendDue[$];
    int          checkCount = 0;
    int          errorCount = 0;
    int          recvCount  = 0;
    int          fireCount  = 0;
    int          cycleCnt   = 0;
    int          minLat     = 0;
    int          maxLat     = 0;
    bit          halted     = 0;

    instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_misaligned  (if_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a scrambled function of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) + 32'h0000_0001;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Everything decode should see from a new fetch starting point.
    task automatic startSegment(input logic [31:0] rawTarget);
        logic [31:0] t;
        t = {rawTarget[31:1], 1'b0};
        expQ.delete();
        if (t[1]) begin
            expQ.push_back('{pc: t, instr: NOP_INSTR, mis: 1'b1});
            halted = 1'b1;
        end else begin
            for (int i = 0; i < 512; i++) begin
                expQ.push_back('{pc: t + 32'(4 * i), instr: memWord(t + 32'(4 * i)), mis: 1'b0});
            end
            halted = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic ifRdy, input logic reqRdy);
        redirect_valid = redir;
        redirect_pc    = rpc;
        if_ready       = ifRdy;
        imem_req_ready = reqRdy;
        if (redir) begin
            startSegment(rpc);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic waitOutputs(input int n, input int budget);
        int target;
        int cycles;
        target = recvCount + n;
        cycles = 0;
        while (recvCount < target && cycles < budget) begin
            stepCycle();
            cycles++;
        end
        if (recvCount < target) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL wait_outputs actual=%0d expected=%0d", recvCount, target);
        end
    endtask

    task automatic doReset();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        checkOutput("rst_req_addr", imem_req_addr, 32'h0);
        checkOutput("rst_if_valid", {31'b0, if_valid}, 32'h0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_instr", if_instr, 32'h0);
        checkOutput("rst_if_mis", {31'b0, if_misaligned}, 32'h0);
        pendAddr.delete();
        pendDue.delete();
        redirect_valid = 1'b0;
        startSegment(RESET_PC);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Decode-side monitor: every accepted instruction is popped and compared.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready) begin
            if (expQ.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected_output actual_pc=%h expected=none", if_pc);
            end else begin
                expEntry_t e;
                e = expQ.pop_front();
                checkOutput("if_pc", if_pc, e.pc);
                checkOutput("if_instr", if_instr, e.instr);
                checkOutput("if_misaligned", {31'b0, if_misaligned}, {31'b0, e.mis});
            end
            recvCount++;
        end
        if (rst_n && halted) begin
            checkOutput("req_while_halted", {31'b0, imem_req_valid}, 32'h0);
        end
    end

    // Imem request side: accepted requests are queued with a random latency.
    always @(negedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) begin
            pendAddr.push_back(imem_req_addr);
            pendDue.push_back(cycleCnt + 1 + $urandom_range(maxLat, minLat));
            fireCount++;
        end
    end

    // Imem response side: at most one in-order response per cycle.
    always @(posedge clk) begin
        #1;
        cycleCnt++;
        if (rst_n && pendAddr.size() > 0 && pendDue[0] <= cycleCnt) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(pendAddr[0]);
            void'(pendAddr.pop_front());
            void'(pendDue.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int f0;
        logic [31:0] tgt;
        logic redir;
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // Zero-wait imem, decode always ready.
        stepCycle();
        minLat = 0; maxLat = 0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        doReset();
        @(negedge clk);
        checkOutput("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
        checkOutput("first_req_addr", imem_req_addr, RESET_PC);
        waitOutputs(20, 200);

        // Decode stalled: only FIFO_DEPTH requests may be issued.
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        doReset();
        f0 = fireCount;
        repeat (10) stepCycle();
        @(negedge clk);
        checkOutput("stall_req_count", 32'(fireCount - f0), 32'(FIFO_DEPTH));
        checkOutput("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        waitOutputs(12, 200);

        // Redirect with 0x8 and 0xC in flight: both must be dropped.
        stepCycle();
        minLat = 4; maxLat = 4;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        doReset();
        for (int i = 0; i < 100; i++) begin
            stepCycle();
            if (pendAddr.size() == 2 && pendAddr[0] == 32'h8) break;
        end
        checkOutput("inflight_head", pendAddr.size() > 0 ? pendAddr[0] : 32'hFFFF_FFFF, 32'h8);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        waitOutputs(4, 200);

        // JALR target with bit 0 set: fetch at 0x200 in the next cycle.
        minLat = 0; maxLat = 0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (10) stepCycle();
        applyStimulus(1'b1, 32'h201, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("jalr_req_valid", {31'b0, imem_req_valid}, 32'h1);
        checkOutput("jalr_req_addr", imem_req_addr, 32'h200);
        waitOutputs(4, 100);

        // Misaligned target: fault entry held until accepted, then halt.
        stepCycle();
        applyStimulus(1'b1, 32'h102, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("fault_valid", {31'b0, if_valid}, 32'h1);
            checkOutput("fault_mis", {31'b0, if_misaligned}, 32'h1);
            checkOutput("fault_pc", if_pc, 32'h102);
            checkOutput("fault_instr", if_instr, 32'h13);
            stepCycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        waitOutputs(1, 20);
        repeat (5) stepCycle();
        @(negedge clk);
        checkOutput("halt_if_valid", {31'b0, if_valid}, 32'h0);
        stepCycle();
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        waitOutputs(6, 200);

        // Redirect in the same cycle as a would-be handshake.
        minLat = 0; maxLat = 2;
        for (int i = 0; i < 50; i++) begin
            stepCycle();
            if (if_valid) break;
        end
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("redirect_hides_valid", {31'b0, if_valid}, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        waitOutputs(4, 200);

        // Asynchronous reset pulse in the middle of a burst.
        repeat (7) stepCycle();
        doReset();
        waitOutputs(8, 300);

        // Random traffic with random redirects, some misaligned.
        minLat = 0; maxLat = 3;
        for (int i = 0; i < 1500; i++) begin
            stepCycle();
            redir = ($urandom_range(0, 99) < 3);
            tgt   = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 7) == 0) begin
                tgt[1:0] = 2'($urandom_range(1, 3));
            end
            applyStimulus(redir, tgt, ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 75));
        end
        stepCycle();
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        waitOutputs(10, 300);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
